// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack-style A/D CPU with request/acknowledge instruction and data ports.
// Latency: 2 cycles for A/C, 3 for a single M access, 4 for read-modify-write; each wait state adds one cycle.
// Backpressure: requests are held level-stable until ack; a missing ack stalls the FSM in place.
module hack_cpu_mc #(
  parameter int DW = 16,
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  input  logic          imem_ack,
  output logic          dmem_re,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic [AW-1:0] pc,
  output logic          retire,
  output logic          halted
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] EXEC   = 3'd1;
  localparam logic [2:0] MREAD  = 3'd2;
  localparam logic [2:0] MWRITE = 3'd3;
  localparam logic [2:0] HALT   = 3'd4;

  logic [2:0]    state;
  logic [2:0]    nextState;
  logic [DW-1:0] aReg;
  logic [DW-1:0] dReg;
  logic [AW-1:0] pcReg;
  logic [DW-1:0] irReg;
  logic [DW-1:0] mdrReg;
  logic [DW-1:0] alurReg;
  logic          prevA;
  logic          haltedReg;

  logic [DW-1:0] aluX;
  logic [DW-1:0] aluY;
  logic [DW-1:0] aluOut;
  logic          zr;
  logic          ng;
  logic          isA;
  logic          commit;
  logic          loadAlur;
  logic          jumpTaken;
  logic          haltNow;

  assign isA = ~irReg[DW-1];

  // ALU; during the MREAD ack cycle the operand comes straight from the bus so the
  // freshly read word is used in the same edge that captures it into MDR.
  always_comb begin
    aluX = dReg;
    aluY = (state == MREAD) ? dmem_rdata : (irReg[12] ? mdrReg : aReg);
    if (irReg[11]) aluX = '0;
    if (irReg[10]) aluX = ~aluX;
    if (irReg[9])  aluY = '0;
    if (irReg[8])  aluY = ~aluY;
    aluOut = irReg[7] ? (aluX + aluY) : (aluX & aluY);
    if (irReg[6])  aluOut = ~aluOut;
  end

  assign zr = (aluOut == '0);
  assign ng = aluOut[DW-1];
  assign jumpTaken = ~isA & ((irReg[2] & ng) | (irReg[1] & zr) | (irReg[0] & ~ng & ~zr));
  // Self-loop "@L / 0;JMP" where L is the address of the @L itself.
  assign haltNow = ~isA & (irReg[2:0] == 3'b111) & prevA &
                   (aReg == {{(DW-AW){1'b0}}, pcReg - AW'(1)});

  // Next-state and commit decision.
  always_comb begin
    nextState = state;
    commit    = 1'b0;
    loadAlur  = 1'b0;
    case (state)
      FETCH:  if (imem_ack) nextState = EXEC;
      EXEC: begin
        if (isA)            commit = 1'b1;
        else if (irReg[12]) nextState = MREAD;
        else if (irReg[3]) begin
          loadAlur  = 1'b1;
          nextState = MWRITE;
        end else            commit = 1'b1;
      end
      MREAD: begin
        if (dmem_ack) begin
          if (irReg[3]) begin
            loadAlur  = 1'b1;
            nextState = MWRITE;
          end else commit = 1'b1;
        end
      end
      MWRITE: if (dmem_ack) commit = 1'b1;
      HALT:   nextState = HALT;
      default: nextState = FETCH;
    endcase
    if (commit) nextState = haltNow ? HALT : FETCH;
  end

  // Architectural state; A/D/PC only change in the commit edge, using A before the commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      aReg      <= '0;
      dReg      <= '0;
      pcReg     <= '0;
      irReg     <= '0;
      mdrReg    <= '0;
      alurReg   <= '0;
      prevA     <= 1'b0;
      haltedReg <= 1'b0;
    end else begin
      state <= nextState;
      if (state == FETCH && imem_ack) irReg  <= imem_rdata;
      if (state == MREAD && dmem_ack) mdrReg <= dmem_rdata;
      if (loadAlur) alurReg <= aluOut;
      if (commit) begin
        if (isA)           aReg <= {1'b0, irReg[DW-2:0]};
        else if (irReg[5]) aReg <= aluOut;
        if (!isA && irReg[4]) dReg <= aluOut;
        pcReg <= jumpTaken ? aReg[AW-1:0] : pcReg + AW'(1);
        prevA <= isA;
        if (haltNow) haltedReg <= 1'b1;
      end
    end
  end

  assign imem_req   = reset & (state == FETCH);
  assign imem_addr  = pcReg;
  assign dmem_re    = reset & (state == MREAD);
  assign dmem_we    = reset & (state == MWRITE);
  assign dmem_addr  = aReg[AW-1:0];
  assign dmem_wdata = alurReg;
  assign pc         = pcReg;
  assign retire     = commit;
  assign halted     = haltedReg;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc with wait-state-capable ROM/RAM responders.
// Latency: checks commit cycle counts against hand-computed values.
// Backpressure: fetch and data acks are delayed by a programmable number of cycles.
module tb_hack_cpu_mc;
  localparam int DW = 16;
  localparam int AW = 15;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata = '0;
  logic          imem_ack = 1'b0;
  logic          dmem_re;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata = '0;
  logic          dmem_ack = 1'b0;
  logic [AW-1:0] pc;
  logic          retire;
  logic          halted;

  always #5 clk = ~clk;

  hack_cpu_mc #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc(pc), .retire(retire), .halted(halted)
  );

  logic [DW-1:0] rom [0:MSZ-1];
  logic [DW-1:0] ram [0:MSZ-1];

  int imemDelay = 0, dmemDelay = 0, iWait = 0, dWait = 0;
  bit spurious = 1'b0;
  int checks = 0, fails = 0;
  int cycleCnt = 0, retireCnt = 0, weCycles = 0, bothHigh = 0, reqCnt = 0, iaddrUnstable = 0;
  int wrCnt = 0, wrCycle = 0, rdCycle = 0;
  int lastWrAddr = 0, lastWrData = 0, lastRdAddr = 0;
  int retireCycle[$];
  int fetchQ[$];
  bit prevReq = 1'b0;
  logic [AW-1:0] prevAddr = '0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clearCounters();
    cycleCnt = 0; retireCnt = 0; weCycles = 0; bothHigh = 0; reqCnt = 0; iaddrUnstable = 0;
    wrCnt = 0; wrCycle = 0; rdCycle = 0; lastWrAddr = -1; lastWrData = -1; lastRdAddr = -1;
    retireCycle.delete(); fetchQ.delete();
  endtask

  task automatic clearMem();
    for (int i = 0; i < MSZ; i++) begin
      rom[i] = '0;
      ram[i] = '0;
    end
  endtask

  task automatic startRun(input int iD, input int dD);
    reset = 1'b0;
    imemDelay = iD;
    dmemDelay = dD;
    repeat (2) @(posedge clk);
    #1;
    clearCounters();
    reset = 1'b1;
  endtask

  task automatic waitHalt(input string tag, input int budget);
    for (int i = 0; i < budget && !halted; i++) @(posedge clk);
    #1;
    checkVal(tag, halted, 1);
  endtask

  // Memory responders: decide ack for the coming rising edge; record completed accesses.
  initial forever begin
    @(negedge clk);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (imem_req) begin
      if (iWait >= imemDelay) begin
        imem_ack   = 1'b1;
        imem_rdata = rom[imem_addr];
        fetchQ.push_back(int'(imem_addr));
        iWait = 0;
      end else iWait++;
    end else iWait = 0;
    if (dmem_re || dmem_we) begin
      if (dWait >= dmemDelay) begin
        dmem_ack = 1'b1;
        if (dmem_re) begin
          dmem_rdata = ram[dmem_addr];
          lastRdAddr = int'(dmem_addr);
          rdCycle = cycleCnt;
        end
        if (dmem_we) begin
          ram[dmem_addr] = dmem_wdata;
          wrCnt++;
          lastWrAddr = int'(dmem_addr);
          lastWrData = int'(dmem_wdata);
          wrCycle = cycleCnt;
        end
        dWait = 0;
      end else dWait++;
    end else dWait = 0;
    if (spurious) begin
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
    end
  end

  // Cycle monitor, sampled just before each rising edge.
  initial forever begin
    @(negedge clk);
    #3;
    cycleCnt++;
    if (retire) begin
      retireCnt++;
      retireCycle.push_back(cycleCnt);
    end
    if (dmem_we) weCycles++;
    if (dmem_we && dmem_re) bothHigh++;
    if (imem_req) reqCnt++;
    if (imem_req && prevReq && imem_addr != prevAddr) iaddrUnstable++;
    prevReq  = imem_req && !imem_ack;
    prevAddr = imem_addr;
  end

  task automatic loadProg1();
    clearMem();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0003; rom[3] = 16'hE090;
    rom[4] = 16'h0000; rom[5] = 16'hE308; rom[6] = 16'h0006; rom[7] = 16'hEA87;
  endtask

  task automatic loadProg2();
    clearMem();
    rom[0] = 16'h0007; rom[1] = 16'hFDC8; rom[2] = 16'h0002; rom[3] = 16'hEA87;
    ram[7] = 16'd41;
  endtask

  int expFetch [15] = '{0, 1, 2, 3, 5, 6, 7, 8, 12, 13, 14, 32767, 0, 10, 11};
  int baseRetire;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_imem_req", imem_req, 0);
    checkVal("rst_dmem_re", dmem_re, 0);
    checkVal("rst_dmem_we", dmem_we, 0);
    checkVal("rst_retire", retire, 0);
    checkVal("rst_halted", halted, 0);
    checkVal("rst_pc", pc, 0);
    checkVal("rst_imem_addr", imem_addr, 0);
    checkVal("rst_dmem_addr", dmem_addr, 0);
    checkVal("rst_dmem_wdata", dmem_wdata, 0);

    // Zero-wait: @5; D=A; @3; D=D+A; @0; M=D; then @6; 0;JMP halt
    loadProg1();
    startRun(0, 0);
    waitHalt("p1_halt", 100);
    checkVal("p1_sixth_retire_cycle", (retireCycle.size() > 5) ? retireCycle[5] : -1, 13);
    checkVal("p1_retires", retireCnt, 8);
    checkVal("p1_wr_cnt", wrCnt, 1);
    checkVal("p1_wr_addr", lastWrAddr, 0);
    checkVal("p1_wr_data", lastWrData, 8);
    checkVal("p1_we_cycles", weCycles, 1);
    checkVal("p1_pc_halt", pc, 6);
    checkVal("p1_re_we_both", bothHigh, 0);

    // Same program with 3 fetch wait states
    loadProg1();
    startRun(3, 0);
    waitHalt("p1w_halt", 200);
    checkVal("p1w_sixth_retire_cycle", (retireCycle.size() > 5) ? retireCycle[5] : -1, 31);
    checkVal("p1w_wr_data", lastWrData, 8);
    checkVal("p1w_we_cycles", weCycles, 1);
    checkVal("p1w_iaddr_stable", iaddrUnstable, 0);

    // Read-modify-write: RAM[7]=41; @7; M=M+1
    loadProg2();
    startRun(0, 0);
    waitHalt("rmw_halt", 100);
    checkVal("rmw_rd_addr", lastRdAddr, 7);
    checkVal("rmw_wr_addr", lastWrAddr, 7);
    checkVal("rmw_wr_data", lastWrData, 42);
    checkVal("rmw_ram7", ram[7], 42);
    checkVal("rmw_latency", (retireCycle.size() > 1) ? retireCycle[1] - retireCycle[0] : -1, 4);
    checkVal("rmw_rd_then_wr", wrCycle - rdCycle, 1);
    checkVal("rmw_re_we_both", bothHigh, 0);

    // RMW with two data wait states per access
    loadProg2();
    startRun(0, 2);
    waitHalt("rmw2_halt", 100);
    checkVal("rmw2_latency", (retireCycle.size() > 1) ? retireCycle[1] - retireCycle[0] : -1, 8);
    checkVal("rmw2_wr_data", lastWrData, 42);

    // Jumps, PC wrap and halt at @10/0;JMP
    clearMem();
    rom[0]  = 16'hE305; rom[1]  = 16'h0005; rom[2]  = 16'hEE90; rom[3]  = 16'hE304;
    rom[4]  = 16'hEA90; rom[5]  = 16'hEA90; rom[6]  = 16'h000C; rom[7]  = 16'hE301;
    rom[8]  = 16'hE302; rom[9]  = 16'hEE90; rom[10] = 16'h000A; rom[11] = 16'hEA87;
    rom[12] = 16'h7FFF; rom[13] = 16'hEE90; rom[14] = 16'hEA87; rom[32767] = 16'h000A;
    startRun(0, 0);
    waitHalt("jmp_halt", 300);
    checkVal("jmp_fetch_count", fetchQ.size(), 15);
    for (int i = 0; i < 15; i++)
      checkVal($sformatf("jmp_fetch%0d", i), (i < fetchQ.size()) ? fetchQ[i] : -1, expFetch[i]);
    checkVal("jmp_pc_halt", pc, 10);
    checkVal("jmp_retires", retireCnt, 15);

    // Halt holds for 20 cycles, even with acks arriving unrequested
    @(posedge clk);
    #1;
    reqCnt = 0;
    baseRetire = retireCnt;
    spurious = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    spurious = 1'b0;
    checkVal("halt_no_req", reqCnt, 0);
    checkVal("halt_no_retire", retireCnt - baseRetire, 0);
    checkVal("halt_pc_hold", pc, 10);
    checkVal("halt_sticky", halted, 1);

    // Reset pulse clears halt and restarts fetching at 0
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkVal("rst_clears_halted", halted, 0);
    checkVal("rst_clears_pc", pc, 0);
    repeat (2) @(posedge clk);
    #1;
    clearCounters();
    reset = 1'b1;
    for (int i = 0; i < 20 && fetchQ.size() == 0; i++) @(posedge clk);
    #1;
    checkVal("restart_fetch_addr", (fetchQ.size() > 0) ? fetchQ[0] : -1, 0);

    // Reset during a stalled MWRITE: @5; D=A; M=D with long data latency
    clearMem();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'hE308;
    startRun(0, 10);
    for (int i = 0; i < 50 && !dmem_we; i++) begin
      @(posedge clk);
      #1;
    end
    checkVal("mw_we_seen", dmem_we, 1);
    #2;
    reset = 1'b0;
    #1;
    checkVal("mw_we_drop", dmem_we, 0);
    checkVal("mw_retire", retire, 0);
    checkVal("mw_pc", pc, 0);
    checkVal("mw_a", dmem_addr, 0);
    checkVal("mw_d", dut.dReg, 0);
    repeat (3) @(posedge clk);
    #1;
    checkVal("mw_retires", retireCnt, 2);
    checkVal("mw_no_write", wrCnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
